// File: rtl/simplebus_sram_responder.sv
// SimpleBus responder backed by a word-organised on-chip SRAM.
// Handles one request at a time; the response pulse comes after a fixed or LFSR-jittered delay.
module simplebus_sram_responder #(
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          LATENCY    = 1,
  parameter bit          RAND_DELAY = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sb_reqValid,
  input  logic [31:0] sb_addr,
  input  logic        sb_wen,
  input  logic [31:0] sb_wdata,
  input  logic [3:0]  sb_wmask,
  output logic        sb_respValid,
  output logic [31:0] sb_rdata,
  output logic        sb_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 4);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    lfsr_q;
  logic [31:0]   addr_q, wdata_q;
  logic          wen_q;
  logic [3:0]    wmask_q;
  logic          resp_q, err_q;
  logic [31:0]   rdata_q;

  logic [31:0]   mem [DEPTH];

  logic [CW-1:0] load_d;
  logic          accept, commit, mem_we, in_range, lfsr_fb;
  logic [31:0]   c_addr, c_wdata, offset, rd_val;
  logic          c_wen;
  logic [3:0]    c_wmask;
  logic [AW-1:0] idx;

  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign load_d  = CW'(LATENCY) + (RAND_DELAY ? CW'(lfsr_q[1:0]) : '0);
  assign accept  = (state_q == IDLE) && sb_reqValid;
  // A zero-length delay commits on the accept edge, straight from the bus inputs.
  assign commit  = (accept && (load_d == '0)) || ((state_q == WAIT) && (cnt_q == CW'(1)));

  assign c_addr   = (state_q == IDLE) ? sb_addr  : addr_q;
  assign c_wdata  = (state_q == IDLE) ? sb_wdata : wdata_q;
  assign c_wen    = (state_q == IDLE) ? sb_wen   : wen_q;
  assign c_wmask  = (state_q == IDLE) ? sb_wmask : wmask_q;

  assign offset   = c_addr - BASE_ADDR;
  assign in_range = offset < 32'(4 * DEPTH);
  assign idx      = offset[AW+1:2];
  assign rd_val   = (!c_wen && in_range) ? mem[idx] : 32'h0;
  assign mem_we   = commit && c_wen && in_range && rst_n;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (c_wmask[b]) mem[idx][8*b +: 8] <= c_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= 8'hA5;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      wmask_q <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      resp_q  <= commit;
      rdata_q <= commit ? rd_val : 32'h0;
      err_q   <= commit && !in_range;
      case (state_q)
        IDLE: begin
          if (sb_reqValid) begin
            addr_q  <= sb_addr;
            wdata_q <= sb_wdata;
            wen_q   <= sb_wen;
            wmask_q <= sb_wmask;
            cnt_q   <= load_d;
            if (RAND_DELAY) lfsr_q <= {lfsr_q[6:0], lfsr_fb};
            state_q <= (load_d == '0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sb_respValid = resp_q;
  assign sb_rdata     = rdata_q;
  assign sb_err       = err_q;
endmodule

// File: tb/tb_simplebus_sram_responder.sv
// Directed bench for simplebus_sram_responder: three instances cover LATENCY=1, LATENCY=0
// and LATENCY=1 with random delay; expected values are hand-computed or scoreboarded.
module tb_simplebus_sram_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   [3];
  logic        wen   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  wmask [3];
  logic        resp  [3];
  logic [31:0] rdata [3];
  logic        err   [3];

  int errors = 0;
  int checks = 0;

  int          lat;
  logic [31:0] rd;
  logic        e, af;

  always #5 clk = ~clk;

  simplebus_sram_responder #(.DEPTH(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(1), .RAND_DELAY(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .sb_reqValid(req[0]), .sb_addr(addr[0]), .sb_wen(wen[0]),
    .sb_wdata(wdata[0]), .sb_wmask(wmask[0]), .sb_respValid(resp[0]), .sb_rdata(rdata[0]), .sb_err(err[0]));

  simplebus_sram_responder #(.DEPTH(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(0), .RAND_DELAY(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .sb_reqValid(req[1]), .sb_addr(addr[1]), .sb_wen(wen[1]),
    .sb_wdata(wdata[1]), .sb_wmask(wmask[1]), .sb_respValid(resp[1]), .sb_rdata(rdata[1]), .sb_err(err[1]));

  simplebus_sram_responder #(.DEPTH(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(1), .RAND_DELAY(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .sb_reqValid(req[2]), .sb_addr(addr[2]), .sb_wen(wen[2]),
    .sb_wdata(wdata[2]), .sb_wmask(wmask[2]), .sb_respValid(resp[2]), .sb_rdata(rdata[2]), .sb_err(err[2]));

  // Drives one transaction from a negedge; lat counts negedges after the accept edge.
  task automatic do_txn(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input bit scramble,
                        output int l, output logic [31:0] r, output logic er, output logic after);
    req[u] = 1'b1; wen[u] = w; addr[u] = a; wdata[u] = d; wmask[u] = m;
    @(posedge clk);
    l = -1; r = 'x; er = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (scramble && n == 1) begin
        req[u] = 1'b0; addr[u] = a + 32'd4; wdata[u] = ~d; wmask[u] = ~m; wen[u] = ~w;
      end
      if (resp[u]) begin l = n; r = rdata[u]; er = err[u]; break; end
    end
    req[u] = 1'b0;
    @(negedge clk);
    after = resp[u];
  endtask

  task automatic test_reset();
    for (int u = 0; u < 3; u++) begin
      req[u] = 1'b0; wen[u] = 1'b0; addr[u] = '0; wdata[u] = '0; wmask[u] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      checks++;
      if ({resp[u], rdata[u], err[u]} !== 34'h0) begin
        errors++; $display("FAIL reset_out[%0d] got=%b/%h/%b exp=0/0/0", u, resp[u], rdata[u], err[u]);
      end
    end
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
        checks++;
        if ({resp[u], rdata[u], err[u]} !== 34'h0) begin
          errors++; $display("FAIL idle_out[%0d] cyc=%0d got=%b/%h/%b exp=0/0/0", u, n, resp[u], rdata[u], err[u]);
        end
      end
    end
  endtask

  task automatic test_write_read();
    do_txn(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, lat, rd, e, af);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_lat got=%0d exp=2", lat); end
    checks++; if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL wr_resp got=%h/%b exp=0/0", rd, e); end
    checks++; if (af !== 1'b0) begin errors++; $display("FAIL wr_width got=%b exp=0", af); end
    do_txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 1'b0, lat, rd, e, af);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rd_lat got=%0d exp=2", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin errors++; $display("FAIL rd_data got=%h/%b exp=deadbeef/0", rd, e); end
    checks++; if (af !== 1'b0) begin errors++; $display("FAIL rd_width got=%b exp=0", af); end
    do_txn(0, 1'b0, 32'h8000_0013, 32'h0, 4'h0, 1'b0, lat, rd, e, af);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_unaligned got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_byte_mask();
    do_txn(0, 1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 1'b0, lat, rd, e, af);
    do_txn(0, 1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 1'b0, lat, rd, e, af);
    do_txn(0, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 1'b0, lat, rd, e, af);
    checks++; if (rd !== 32'h11BB_33DD) begin errors++; $display("FAIL byte_mask got=%h exp=11bb33dd", rd); end
    do_txn(0, 1'b1, 32'h8000_0020, 32'h5555_5555, 4'h0, 1'b0, lat, rd, e, af);
    checks++; if (lat !== 2 || e !== 1'b0) begin errors++; $display("FAIL mask0_resp got=%0d/%b exp=2/0", lat, e); end
    do_txn(0, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 1'b0, lat, rd, e, af);
    checks++; if (rd !== 32'h11BB_33DD) begin errors++; $display("FAIL mask0_data got=%h exp=11bb33dd", rd); end
  endtask

  task automatic test_out_of_range();
    do_txn(0, 1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 1'b0, lat, rd, e, af);
    do_txn(0, 1'b1, 32'h8000_0FFC, 32'h0BAD_BEEF, 4'hF, 1'b0, lat, rd, e, af);
    do_txn(0, 1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, 1'b0, lat, rd, e, af);
    checks++; if (lat !== 2 || e !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL oor_wr got=%0d/%b/%h exp=2/1/0", lat, e, rd); end
    do_txn(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 1'b0, lat, rd, e, af);
    checks++; if (lat !== 2 || e !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL oor_rd got=%0d/%b/%h exp=2/1/0", lat, e, rd); end
    checks++; if (af !== 1'b0) begin errors++; $display("FAIL oor_width got=%b exp=0", af); end
    do_txn(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 1'b0, lat, rd, e, af);
    checks++; if (rd !== 32'hCAFE_F00D || e !== 1'b0) begin
      errors++; $display("FAIL oor_word0 got=%h/%b exp=cafef00d/0", rd, e); end
    do_txn(0, 1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 1'b0, lat, rd, e, af);
    checks++; if (rd !== 32'h0BAD_BEEF || e !== 1'b0) begin
      errors++; $display("FAIL last_word got=%h/%b exp=0badbeef/0", rd, e); end
  endtask

  task automatic test_latched();
    do_txn(0, 1'b1, 32'h8000_0034, 32'h0000_0000, 4'hF, 1'b0, lat, rd, e, af);
    do_txn(0, 1'b1, 32'h8000_0030, 32'h5566_7788, 4'hF, 1'b1, lat, rd, e, af);
    checks++; if (lat !== 2 || e !== 1'b0) begin errors++; $display("FAIL latch_resp got=%0d/%b exp=2/0", lat, e); end
    do_txn(0, 1'b0, 32'h8000_0030, 32'h0, 4'h0, 1'b0, lat, rd, e, af);
    checks++; if (rd !== 32'h5566_7788) begin errors++; $display("FAIL latch_data got=%h exp=55667788", rd); end
    do_txn(0, 1'b0, 32'h8000_0034, 32'h0, 4'h0, 1'b0, lat, rd, e, af);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL latch_neighbor got=%h exp=0", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wv [3];
    int          pc [3];
    logic [31:0] pd [3];
    int          pulses;
    wv[0] = 32'h0101_0101; wv[1] = 32'h2020_2020; wv[2] = 32'h3C3C_3C3C;
    for (int i = 0; i < 3; i++) begin
      do_txn(1, 1'b1, 32'h8000_0100 + 32'(4*i), wv[i], 4'hF, 1'b0, lat, rd, e, af);
      checks++; if (lat !== 1) begin errors++; $display("FAIL l0_wr_lat[%0d] got=%0d exp=1", i, lat); end
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin pc[i] = -1; pd[i] = 'x; end
    req[1] = 1'b1; wen[1] = 1'b0; addr[1] = 32'h8000_0100;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (resp[1]) begin
        if (pulses < 3) begin pc[pulses] = n; pd[pulses] = rdata[1]; end
        pulses++;
        if (pulses < 3) addr[1] = 32'h8000_0100 + 32'(4*pulses);
        else req[1] = 1'b0;
      end
    end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", pulses); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (pc[i] !== 2*i+1) begin errors++; $display("FAIL b2b_cycle[%0d] got=%0d exp=%0d", i, pc[i], 2*i+1); end
      checks++; if (pd[i] !== wv[i]) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, pd[i], wv[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] model [8];
    int          lmin, lmax, k;
    lmin = 99; lmax = -1;
    for (int i = 0; i < 8; i++) begin
      model[i] = 32'h9000_0000 + 32'(i * 32'h0111_1111);
      do_txn(2, 1'b1, 32'h8000_0000 + 32'(4*i), model[i], 4'hF, 1'b0, lat, rd, e, af);
      checks++; if (lat < 2 || lat > 5) begin errors++; $display("FAIL rnd_wr_lat[%0d] got=%0d exp=2..5", i, lat); end
    end
    for (int t = 0; t < 200; t++) begin
      k = $urandom_range(7, 0);
      do_txn(2, 1'b0, 32'h8000_0000 + 32'(4*k), 32'h0, 4'h0, 1'b0, lat, rd, e, af);
      if (lat < lmin) lmin = lat;
      if (lat > lmax) lmax = lat;
      checks++; if (lat < 2 || lat > 5) begin errors++; $display("FAIL rnd_lat[%0d] got=%0d exp=2..5", t, lat); end
      checks++; if (rd !== model[k] || e !== 1'b0) begin
        errors++; $display("FAIL rnd_data[%0d] got=%h/%b exp=%h/0", t, rd, e, model[k]); end
    end
    checks++; if (lmin == lmax) begin errors++; $display("FAIL rnd_spread got=%0d..%0d exp=varying", lmin, lmax); end

    req[2] = 1'b1; wen[2] = 1'b1; addr[2] = 32'h8000_000C; wdata[2] = 32'hFFFF_0000; wmask[2] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    af = 1'b0;
    repeat (2) begin @(negedge clk); af = af | resp[2]; end
    req[2] = 1'b0;
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); af = af | resp[2]; end
    checks++; if (af !== 1'b0) begin errors++; $display("FAIL rst_abort_resp got=%b exp=0", af); end
    do_txn(2, 1'b0, 32'h8000_000C, 32'h0, 4'h0, 1'b0, lat, rd, e, af);
    checks++; if (rd !== model[3]) begin errors++; $display("FAIL rst_abort_mem got=%h exp=%h", rd, model[3]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_out_of_range();
    test_latched();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
